// File: rtl/output_router.sv
// Output-side partial-sum router: captures one psum per PE lane on a strobe, then
// drains them one lane per cycle to output SRAM at consecutive addresses.
module output_router #(
    parameter int ROUTER_COUNT = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                               i_clk,
    input  logic                               i_nrst,
    input  logic                               i_reg_clear,
    input  logic                               i_psum_out_en,
    input  logic [ROUTER_COUNT*DATA_WIDTH-1:0] i_psum,
    input  logic [ADDR_WIDTH-1:0]              i_addr_base,
    input  logic                               i_en,
    output logic                               o_wr_en,
    output logic [ADDR_WIDTH-1:0]              o_addr,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic                               o_done,
    output logic                               o_overrun
);

    // Index must be able to reach ROUTER_COUNT to mark "all lanes written".
    localparam int IDX_W = $clog2(ROUTER_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADED,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                                  state_q, state_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]                   base_q, base_d;
    logic [ROUTER_COUNT-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
    logic                                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]                   data_q, data_d;
    logic                                    done_q, done_d;
    logic                                    overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]                   lane_sel;

    always_comb begin
        lane_sel = '0;
        for (int k = 0; k < ROUTER_COUNT; k++) begin
            if (idx_q == IDX_W'(k)) lane_sel = lane_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        lane_d    = lane_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        overrun_d = overrun_q;

        if (i_reg_clear) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            base_d    = '0;
            lane_d    = '0;
            addr_d    = '0;
            data_d    = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end else if (i_psum_out_en && (state_q == S_IDLE || state_q == S_DONE)) begin
            lane_d  = i_psum;
            base_d  = i_addr_base;
            idx_d   = '0;
            done_d  = 1'b0;
            state_d = S_LOADED;
        end else begin
            // A strobe while data is still held is dropped, but the drain carries on.
            if (i_psum_out_en) overrun_d = 1'b1;
            if (i_en) begin
                unique case (state_q)
                    S_LOADED: begin
                        wr_en_d = 1'b1;
                        addr_d  = base_q;
                        data_d  = lane_q[0];
                        idx_d   = IDX_W'(1);
                        state_d = S_WRITE;
                    end
                    S_WRITE: begin
                        if (idx_q == IDX_W'(ROUTER_COUNT)) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            wr_en_d = 1'b1;
                            addr_d  = base_q + ADDR_WIDTH'(idx_q);
                            data_d  = lane_sel;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            lane_q    <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            lane_q    <= lane_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;
    assign o_done    = done_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_output_router.sv
// Bench for output_router: directed test-plan scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level model.
module tb_output_router;
    localparam int RC = 4;
    localparam int DW = 8;
    localparam int AW = 8;

    logic              i_clk = 1'b0;
    logic              i_nrst = 1'b0;
    logic              i_reg_clear = 1'b0;
    logic              i_psum_out_en = 1'b0;
    logic [RC*DW-1:0]  i_psum = '0;
    logic [AW-1:0]     i_addr_base = '0;
    logic              i_en = 1'b0;
    logic              o_wr_en;
    logic [AW-1:0]     o_addr;
    logic [DW-1:0]     o_data;
    logic              o_done;
    logic              o_overrun;

    output_router #(.ROUTER_COUNT(RC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
        .i_psum_out_en(i_psum_out_en), .i_psum(i_psum), .i_addr_base(i_addr_base),
        .i_en(i_en), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_data(o_data),
        .o_done(o_done), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a held batch of lanes, how many beats have gone out, and sticky flags.
    logic          m_held;
    logic [DW-1:0] m_lane [RC];
    int            m_base;
    int            m_sent;
    logic          m_done, m_ovr, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    logic [15:0] wr_log [$];

    task automatic model_reset();
        m_held = 0; m_base = 0; m_sent = 0;
        m_done = 0; m_ovr = 0; m_wr = 0; m_addr = '0; m_data = '0;
        for (int k = 0; k < RC; k++) m_lane[k] = '0;
    endtask

    task automatic model_edge();
        if (!i_nrst || i_reg_clear) begin
            model_reset();
        end else if (i_psum_out_en && !m_held) begin
            for (int k = 0; k < RC; k++) m_lane[k] = i_psum[k*DW +: DW];
            m_base = int'(i_addr_base);
            m_held = 1; m_sent = 0; m_done = 0; m_wr = 0;
        end else begin
            if (i_psum_out_en) m_ovr = 1;
            m_wr = 0;
            if (i_en && m_held) begin
                if (m_sent < RC) begin
                    m_wr   = 1;
                    m_addr = AW'((m_base + m_sent) % (1 << AW));
                    m_data = m_lane[m_sent];
                    m_sent++;
                end else begin
                    m_done = 1;
                    m_held = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".wr_en"}, 32'(o_wr_en), 32'(m_wr));
        chk({ctx, ".addr"}, 32'(o_addr), 32'(m_addr));
        chk({ctx, ".data"}, 32'(o_data), 32'(m_data));
        chk({ctx, ".done"}, 32'(o_done), 32'(m_done));
        chk({ctx, ".overrun"}, 32'(o_overrun), 32'(m_ovr));
        if (o_wr_en) wr_log.push_back({o_addr, o_data});
    endtask

    task automatic step(input string ctx, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            model_edge();
            @(negedge i_clk);
            check_all(ctx);
        end
    endtask

    task automatic capture(input string ctx, input logic [31:0] psum, input logic [7:0] base);
        i_psum = psum; i_addr_base = base; i_psum_out_en = 1;
        step(ctx);
        i_psum_out_en = 0;
    endtask

    task automatic clear(input string ctx);
        i_reg_clear = 1; step(ctx); i_reg_clear = 0;
    endtask

    task automatic chk_log(input string ctx, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        chk({ctx, ".nbeats"}, 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            chk($sformatf("%s.beat%0d", ctx, i), 32'(wr_log[i]), 32'(exp[i]));
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge i_clk);
        i_nrst = 1;
        step("idle", 2);

        // Basic drain
        capture("basic", 32'h44332211, 8'h10);
        wr_log.delete();
        i_en = 1;
        step("basic", 7);
        chk_log("basic", 16'h1011, 16'h1122, 16'h1233, 16'h1344);
        chk("basic.done_held", 32'(o_done), 32'd1);
        i_en = 0;

        // Stall after second beat
        clear("stall");
        capture("stall", 32'h44332211, 8'h10);
        wr_log.delete();
        i_en = 1; step("stall", 2);
        i_en = 0; step("stall_gap", 3);
        i_en = 1; step("stall", 4);
        chk_log("stall", 16'h1011, 16'h1122, 16'h1233, 16'h1344);
        chk("stall.done", 32'(o_done), 32'd1);
        i_en = 0;

        // Address wrap
        clear("wrap");
        capture("wrap", 32'hDDCCBBAA, 8'hFE);
        wr_log.delete();
        i_en = 1; step("wrap", 6);
        chk_log("wrap", 16'hFEAA, 16'hFFBB, 16'h00CC, 16'h01DD);
        i_en = 0;

        // Overrun during WRITE
        clear("ovr");
        capture("ovr", 32'h0D0C0B0A, 8'h40);
        wr_log.delete();
        i_en = 1; step("ovr", 2);
        i_psum = 32'hEEEEEEEE; i_addr_base = 8'h99; i_psum_out_en = 1;
        step("ovr");
        i_psum_out_en = 0;
        step("ovr", 4);
        chk_log("ovr", 16'h400A, 16'h410B, 16'h420C, 16'h430D);
        chk("ovr.flag", 32'(o_overrun), 32'd1);
        i_en = 0;

        // Clear in DONE, then re-capture
        clear("clr");
        chk("clr.done", 32'(o_done), 32'd0);
        capture("clr", 32'h87654321, 8'h20);
        wr_log.delete();
        i_en = 1; step("clr", 6);
        chk_log("clr", 16'h2021, 16'h2143, 16'h2265, 16'h2387);
        i_en = 0;

        // Asynchronous reset mid-drain
        clear("arst");
        capture("arst", 32'h55667788, 8'h30);
        i_en = 1; step("arst", 2);
        #2 i_nrst = 0;
        #1 model_reset();
        check_all("arst_now");
        step("arst_hold");
        i_nrst = 1;
        wr_log.delete();
        step("arst_after", 4);
        chk("arst.no_writes", 32'(wr_log.size()), 32'd0);
        i_en = 0;

        // Clear and capture together: clear wins
        i_reg_clear = 1; i_psum_out_en = 1; i_psum = 32'h12345678; i_addr_base = 8'h50;
        step("clrcap");
        i_reg_clear = 0; i_psum_out_en = 0;
        wr_log.delete();
        i_en = 1; step("clrcap", 4);
        chk("clrcap.no_writes", 32'(wr_log.size()), 32'd0);
        i_en = 0;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            i_reg_clear   = ($urandom_range(0, 39) == 0);
            i_psum_out_en = ($urandom_range(0, 7) == 0);
            i_en          = ($urandom_range(0, 3) != 0);
            i_psum        = $urandom;
            i_addr_base   = AW'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
